// File: rtl/vram_arbiter_if.sv
// ============================================================================
// Module   : vram_arbiter_if
// Brief    : Client-side request/grant/read-return bundle for vram_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vram_arbiter_if #(
   parameter int NUM_CLIENTS = 2,
   parameter int ADDR_WIDTH  = 15,
   parameter int DATA_WIDTH  = 16
);
   logic [NUM_CLIENTS-1:0]              req;
   logic [NUM_CLIENTS-1:0]              req_wr;
   logic [NUM_CLIENTS*DATA_WIDTH/8-1:0] req_be;
   logic [NUM_CLIENTS*ADDR_WIDTH-1:0]   req_addr;
   logic [NUM_CLIENTS*DATA_WIDTH-1:0]   req_data;
   logic [NUM_CLIENTS-1:0]              gnt;
   logic [NUM_CLIENTS-1:0]              rd_valid;
   logic [DATA_WIDTH-1:0]               rd_data;

   modport master (
      output req, req_wr, req_be, req_addr, req_data,
      input  gnt, rd_valid, rd_data
   );

   modport slave (
      input  req, req_wr, req_be, req_addr, req_data,
      output gnt, rd_valid, rd_data
   );
endinterface

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Brief    : N-client round-robin arbiter for the single VRAM port, with
//            registered VRAM commands and per-client read-return strobes.
//            Optional macro VRAM_ARB_PRIORITY_EN gives client 0 absolute priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vram_arbiter #(
   parameter int NUM_CLIENTS  = 2,
   parameter int ADDR_WIDTH   = 15,
   parameter int DATA_WIDTH   = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    _reset,
   vram_arbiter_if.slave           bus,
   output logic                    vram_en,
   output logic                    vram_rd,
   output logic                    vram_wr,
   output logic [DATA_WIDTH/8-1:0] vram_be,
   output logic [ADDR_WIDTH-1:0]   vram_addr,
   output logic [DATA_WIDTH-1:0]   vram_data_out,
   input  logic [DATA_WIDTH-1:0]   vram_data_in
);
   localparam int c_cw = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int c_pw = c_cw + 1;
   localparam int c_bw = DATA_WIDTH / 8;

   logic [c_cw-1:0]                 r_rr_ptr;
   logic [NUM_CLIENTS-1:0]          w_req_rr;
   logic [NUM_CLIENTS-1:0]          w_gnt;
   logic                            w_hit;
   logic                            w_pri;
   logic                            w_is_rd;
   logic [c_cw-1:0]                 w_idx;
   logic [c_cw-1:0]                 w_ptr_nxt;
   logic [c_pw-1:0]                 w_pos;
   logic [NUM_CLIENTS-1:0]          r_rd_valid;
   logic [DATA_WIDTH-1:0]           r_rd_data;
   logic [READ_LATENCY:0]           r_trk_vld;
   logic [READ_LATENCY:0][c_cw-1:0] r_trk_idx;

   // Search starts at r_rr_ptr; the wrap is an explicit subtract so that
   // non-power-of-two client counts never alias onto a missing client.
   always_comb begin : p_arb
      w_req_rr = bus.req;
      w_pri    = 1'b0;
      w_hit    = 1'b0;
      w_idx    = '0;
      w_pos    = '0;
      w_gnt    = '0;
`ifdef VRAM_ARB_PRIORITY_EN
      w_req_rr[0] = 1'b0;
`endif
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         w_pos = {1'b0, r_rr_ptr} + c_pw'(i);
         if (w_pos >= c_pw'(NUM_CLIENTS)) begin
            w_pos = w_pos - c_pw'(NUM_CLIENTS);
         end
         if (!w_hit && w_req_rr[w_pos[c_cw-1:0]]) begin
            w_hit = 1'b1;
            w_idx = w_pos[c_cw-1:0];
         end
      end
`ifdef VRAM_ARB_PRIORITY_EN
      // Renderer wins outright and leaves the round-robin pointer untouched.
      if (bus.req[0]) begin
         w_hit = 1'b1;
         w_pri = 1'b1;
         w_idx = '0;
      end
`endif
      if (w_hit) begin
         w_gnt[w_idx] = _reset;
      end
   end

   assign w_ptr_nxt    = (w_idx == c_cw'(NUM_CLIENTS - 1)) ? '0 : w_idx + c_cw'(1);
   assign w_is_rd      = w_hit & ~bus.req_wr[w_idx];
   assign bus.gnt      = w_gnt;
   assign bus.rd_valid = r_rd_valid;
   assign bus.rd_data  = r_rd_data;

   always_ff @(posedge clk or negedge _reset) begin : p_cmd
      if (!_reset) begin
         r_rr_ptr      <= '0;
         vram_en       <= 1'b0;
         vram_rd       <= 1'b0;
         vram_wr       <= 1'b0;
         vram_be       <= '0;
         vram_addr     <= '0;
         vram_data_out <= '0;
      end else begin
         vram_en <= w_hit;
         vram_rd <= w_is_rd;
         vram_wr <= w_hit & bus.req_wr[w_idx];
         vram_be <= w_hit ? bus.req_be[w_idx*c_bw +: c_bw] : '0;
         if (w_hit) begin
            vram_addr     <= bus.req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
            vram_data_out <= bus.req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
         end
         if (w_hit && !w_pri) begin
            r_rr_ptr <= w_ptr_nxt;
         end
      end
   end

   // Stage j holds the read issued j+1 cycles ago; the last stage lines up
   // with valid vram_data_in.
   always_ff @(posedge clk or negedge _reset) begin : p_ret
      if (!_reset) begin
         r_trk_vld  <= '0;
         r_trk_idx  <= '0;
         r_rd_valid <= '0;
         r_rd_data  <= '0;
      end else begin
         r_trk_vld  <= {r_trk_vld[READ_LATENCY-1:0], w_is_rd};
         r_trk_idx  <= {r_trk_idx[READ_LATENCY-1:0], w_idx};
         r_rd_valid <= '0;
         if (r_trk_vld[READ_LATENCY]) begin
            r_rd_valid[r_trk_idx[READ_LATENCY]] <= 1'b1;
            r_rd_data                           <= vram_data_in;
         end
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Scoreboard bench for vram_arbiter (N=2/L=1 and N=3/L=3 instances).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vram_arbiter;
   localparam int L_A = 1;
   localparam int L_B = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_a_n;
   logic reset_b_n;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   vram_arbiter_if #(.NUM_CLIENTS(2), .ADDR_WIDTH(15), .DATA_WIDTH(16)) if_a ();
   vram_arbiter_if #(.NUM_CLIENTS(3), .ADDR_WIDTH(15), .DATA_WIDTH(16)) if_b ();

   logic        en_a, rd_a, wr_a, en_b, rd_b, wr_b;
   logic [1:0]  be_a, be_b;
   logic [14:0] addr_a, addr_b;
   logic [15:0] dout_a, dout_b, din_a, din_b;

   vram_arbiter #(.NUM_CLIENTS(2), .ADDR_WIDTH(15), .DATA_WIDTH(16), .READ_LATENCY(L_A)) u_a (
      .clk(clk), ._reset(reset_a_n), .bus(if_a.slave),
      .vram_en(en_a), .vram_rd(rd_a), .vram_wr(wr_a), .vram_be(be_a),
      .vram_addr(addr_a), .vram_data_out(dout_a), .vram_data_in(din_a)
   );

   vram_arbiter #(.NUM_CLIENTS(3), .ADDR_WIDTH(15), .DATA_WIDTH(16), .READ_LATENCY(L_B)) u_b (
      .clk(clk), ._reset(reset_b_n), .bus(if_b.slave),
      .vram_en(en_b), .vram_rd(rd_b), .vram_wr(wr_b), .vram_be(be_b),
      .vram_addr(addr_b), .vram_data_out(dout_b), .vram_data_in(din_b)
   );

   typedef struct {
      int          cyc;
      logic [63:0] val;
   } ev_t;

   ev_t qg_a[$], qc_a[$], qr_a[$], qg_b[$], qc_b[$], qr_b[$];

   // VRAM model: fixed contents, data appears L cycles after the address.
   function automatic logic [15:0] mem_f(logic [14:0] a);
      return (a == 15'h0123) ? 16'hBEEF : 16'h0100 + {1'b0, a};
   endfunction

   logic [14:0] pa;
   logic [14:0] pb [3];
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      pa    <= addr_a;
      pb[0] <= addr_b;
      pb[1] <= pb[0];
      pb[2] <= pb[1];
   end
   assign din_a = mem_f(pa);
   assign din_b = mem_f(pb[2]);

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(int k, logic wr, logic [1:0] be, logic [14:0] addr, logic [15:0] data);
      if_a.req_wr[k]          = wr;
      if_a.req_be[k*2 +: 2]   = be;
      if_a.req_addr[k*15 +: 15] = addr;
      if_a.req_data[k*16 +: 16] = data;
   endtask

   task automatic set_b(int k, logic wr, logic [1:0] be, logic [14:0] addr, logic [15:0] data);
      if_b.req_wr[k]          = wr;
      if_b.req_be[k*2 +: 2]   = be;
      if_b.req_addr[k*15 +: 15] = addr;
      if_b.req_data[k*16 +: 16] = data;
   endtask

   task automatic exp_a(int k, logic wr, logic [1:0] be, logic [14:0] addr, logic [15:0] data, logic [15:0] rdat);
      ev_t e;
      e.cyc = cyc;         e.val = 64'd1 << k;                          qg_a.push_back(e);
      e.cyc = cyc + 1;     e.val = {29'd0, wr, ~wr, be, addr, data};    qc_a.push_back(e);
      if (!wr) begin
         e.cyc = cyc + L_A + 2; e.val = {46'd0, 2'b01 << k, rdat};      qr_a.push_back(e);
      end
   endtask

   task automatic exp_b(int k, logic wr, logic [1:0] be, logic [14:0] addr, logic [15:0] data, logic [15:0] rdat);
      ev_t e;
      e.cyc = cyc;         e.val = 64'd1 << k;                          qg_b.push_back(e);
      e.cyc = cyc + 1;     e.val = {29'd0, wr, ~wr, be, addr, data};    qc_b.push_back(e);
      if (!wr) begin
         e.cyc = cyc + L_B + 2; e.val = {45'd0, 3'b001 << k, rdat};     qr_b.push_back(e);
      end
   endtask

   always @(negedge clk) begin : mon_a
      ev_t e;
      if (if_a.gnt != '0) begin
         if (qg_a.size() == 0) chk("a_gnt_unexpected", 64'(if_a.gnt), 64'd0);
         else begin
            e = qg_a.pop_front();
            chk("a_gnt", 64'(if_a.gnt), e.val);
            chk("a_gnt_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      if (en_a) begin
         if (qc_a.size() == 0) chk("a_cmd_unexpected", 64'(en_a), 64'd0);
         else begin
            e = qc_a.pop_front();
            chk("a_cmd", {29'd0, wr_a, rd_a, be_a, addr_a, dout_a}, e.val);
            chk("a_cmd_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      if (if_a.rd_valid != '0) begin
         if (qr_a.size() == 0) chk("a_rd_unexpected", 64'(if_a.rd_valid), 64'd0);
         else begin
            e = qr_a.pop_front();
            chk("a_rd", {46'd0, if_a.rd_valid, if_a.rd_data}, e.val);
            chk("a_rd_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      ev_t e;
      if (if_b.gnt != '0) begin
         if (qg_b.size() == 0) chk("b_gnt_unexpected", 64'(if_b.gnt), 64'd0);
         else begin
            e = qg_b.pop_front();
            chk("b_gnt", 64'(if_b.gnt), e.val);
            chk("b_gnt_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      if (en_b) begin
         if (qc_b.size() == 0) chk("b_cmd_unexpected", 64'(en_b), 64'd0);
         else begin
            e = qc_b.pop_front();
            chk("b_cmd", {29'd0, wr_b, rd_b, be_b, addr_b, dout_b}, e.val);
            chk("b_cmd_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      if (if_b.rd_valid != '0) begin
         if (qr_b.size() == 0) chk("b_rd_unexpected", 64'(if_b.rd_valid), 64'd0);
         else begin
            e = qr_b.pop_front();
            chk("b_rd", {45'd0, if_b.rd_valid, if_b.rd_data}, e.val);
            chk("b_rd_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   initial begin
      reset_a_n     = 1'b0;
      reset_b_n     = 1'b0;
      if_a.req      = 2'b11;
      if_a.req_wr   = '0;
      if_a.req_be   = '0;
      if_a.req_addr = '0;
      if_a.req_data = '0;
      if_b.req      = '0;
      if_b.req_wr   = '0;
      if_b.req_be   = '0;
      if_b.req_addr = '0;
      if_b.req_data = '0;
      repeat (2) step();

      // Reset state; grant must stay low even with requests pending.
      chk("a_rst_gnt", 64'(if_a.gnt), 64'd0);
      chk("a_rst_rd", {46'd0, if_a.rd_valid, if_a.rd_data}, 64'd0);
      chk("a_rst_cmd", {29'd0, en_a, rd_a, wr_a, be_a, addr_a, dout_a}, 64'd0);
      chk("b_rst_rd", {45'd0, if_b.rd_valid, if_b.rd_data}, 64'd0);
      chk("b_rst_cmd", {29'd0, en_b, rd_b, wr_b, be_b, addr_b, dout_b}, 64'd0);
      if_a.req  = '0;
      reset_a_n = 1'b1;
      reset_b_n = 1'b1;
      step();

      // Single read on client 1, then a partial-byte write on client 0.
      set_a(1, 1'b0, 2'b11, 15'h0123, 16'h0000);
      if_a.req = 2'b10;
      exp_a(1, 1'b0, 2'b11, 15'h0123, 16'h0000, 16'hBEEF);
      step();
      if_a.req = '0;
      step();
      set_a(0, 1'b1, 2'b10, 15'h7FFF, 16'hA55A);
      if_a.req = 2'b01;
      exp_a(0, 1'b1, 2'b10, 15'h7FFF, 16'hA55A, 16'h0000);
      step();
      if_a.req = '0;
      step();
      chk("a_idle_strobes", {61'd0, en_a, rd_a, wr_a}, 64'd0);
      chk("a_idle_be", 64'(be_a), 64'd0);
      chk("a_idle_hold", {33'd0, addr_a, dout_a}, {33'd0, 15'h7FFF, 16'hA55A});

      for (int k = 0; k < 3; k++) set_b(k, 1'b1, 2'b11, 15'(16 + k), 16'(4096 + k));
`ifdef VRAM_ARB_PRIORITY_EN
      if_b.req = 3'b111;
      repeat (4) begin
         exp_b(0, 1'b1, 2'b11, 15'h10, 16'h1000, 16'h0);
         step();
      end
      if_b.req = 3'b110;
      exp_b(1, 1'b1, 2'b11, 15'h11, 16'h1001, 16'h0); step();
      exp_b(2, 1'b1, 2'b11, 15'h12, 16'h1002, 16'h0); step();
      exp_b(1, 1'b1, 2'b11, 15'h11, 16'h1001, 16'h0); step();
`else
      if_b.req = 3'b111;
      for (int i = 0; i < 6; i++) begin
         exp_b(i % 3, 1'b1, 2'b11, 15'(16 + i % 3), 16'(4096 + i % 3), 16'h0);
         step();
      end
      if_b.req = 3'b101;
      for (int i = 0; i < 4; i++) begin
         exp_b((i % 2) * 2, 1'b1, 2'b11, 15'(16 + (i % 2) * 2), 16'(4096 + (i % 2) * 2), 16'h0);
         step();
      end
`endif
      if_b.req = '0;
      step();

      // Back-to-back reads alternating clients 0/1, addresses 0..7.
      for (int i = 0; i < 8; i++) begin
         set_b(i % 2, 1'b0, 2'b11, 15'(i), 16'h0000);
         if_b.req = 3'b001 << (i % 2);
         exp_b(i % 2, 1'b0, 2'b11, 15'(i), 16'h0000, 16'(256 + i));
         step();
      end
      if_b.req = '0;
      repeat (6) step();

      // Reset one cycle after a read grant: the read must vanish.
      set_b(1, 1'b0, 2'b11, 15'h0055, 16'h0000);
      if_b.req = 3'b010;
      begin
         ev_t e;
         e.cyc = cyc; e.val = 64'd2; qg_b.push_back(e);
      end
      step();
      if_b.req  = '0;
      reset_b_n = 1'b0;
      #1;
      chk("b_midrst_gnt", 64'(if_b.gnt), 64'd0);
      chk("b_midrst_rd", {45'd0, if_b.rd_valid, if_b.rd_data}, 64'd0);
      chk("b_midrst_cmd", {29'd0, en_b, rd_b, wr_b, be_b, addr_b, dout_b}, 64'd0);
      step();
      step();
      reset_b_n = 1'b1;
      step();
      set_b(1, 1'b0, 2'b11, 15'h0060, 16'h0000);
      set_b(2, 1'b0, 2'b11, 15'h0061, 16'h0000);
      if_b.req = 3'b110;
      exp_b(1, 1'b0, 2'b11, 15'h0060, 16'h0000, 16'h0160);
      step();
      if_b.req = '0;
      repeat (10) step();

      chk("a_gnt_left", 64'(qg_a.size()), 64'd0);
      chk("a_cmd_left", 64'(qc_a.size()), 64'd0);
      chk("a_rd_left",  64'(qr_a.size()), 64'd0);
      chk("b_gnt_left", 64'(qg_b.size()), 64'd0);
      chk("b_cmd_left", 64'(qc_b.size()), 64'd0);
      chk("b_rd_left",  64'(qr_b.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Parametrised N-client arbiter for the single external VRAM port.
- Replaces the two-way MEM_CTRL-bit mux between the MPU and the renderer.
- Clients (renderer fetch, MPU, future sprite/blitter engines) request word accesses. A round-robin arbiter grants one access per cycle and drives registered VRAM command signals.
- Read data returns to the requesting client with a per-client valid strobe after a fixed latency.

Parameters:
- NUM_CLIENTS, 2, number of requesting clients (1..8); client index width CW = max(1, clog2(NUM_CLIENTS)).
- ADDR_WIDTH, 15, VRAM word address width.
- DATA_WIDTH, 16, VRAM data width; byte-enable width is DATA_WIDTH/8.
- READ_LATENCY, 1, cycles from vram_en (read) to valid vram_data_in (1..4).

Ports:
- clk  in  1  system clock
- _reset  in  1  asynchronous reset, active low
- req  in  NUM_CLIENTS  per-client access request, held until granted
- req_wr  in  NUM_CLIENTS  per-client: 1 = write, 0 = read
- req_be  in  NUM_CLIENTS*DATA_WIDTH/8  per-client byte enables (active high), client k at slice k
- req_addr  in  NUM_CLIENTS*ADDR_WIDTH  per-client word address, client k at slice k
- req_data  in  NUM_CLIENTS*DATA_WIDTH  per-client write data
- gnt  out  NUM_CLIENTS  one-hot grant, combinational, same cycle as accepted req
- rd_valid  out  NUM_CLIENTS  one-hot read-return strobe, registered
- rd_data  out  DATA_WIDTH  read-return data, shared, valid when any rd_valid bit is set
- vram_en  out  1  VRAM access enable (active high, registered)
- vram_rd  out  1  VRAM read strobe (active high, registered)
- vram_wr  out  1  VRAM write strobe (active high, registered)
- vram_be  out  DATA_WIDTH/8  VRAM byte enables (active high, registered)
- vram_addr  out  ADDR_WIDTH  VRAM address (registered)
- vram_data_out  out  DATA_WIDTH  VRAM write data (registered)
- vram_data_in  in  DATA_WIDTH  VRAM read data

Behaviour:
- Reset (_reset low, async): gnt, rd_valid, rd_data, vram_en, vram_rd, vram_wr, vram_be, vram_addr and vram_data_out all clear to 0; rr_ptr = 0; in-flight read pipeline cleared.
- Arbitration (cycle t): search req starting at rd index rr_ptr, wrapping modulo NUM_CLIENTS; the first asserted client k gets gnt[k]=1. At most one gnt bit is set; gnt is 0 when req is 0.
- Pointer update: on a grant, rr_ptr <= (k+1) mod NUM_CLIENTS at the clock edge. No grant leaves rr_ptr unchanged.
- Wrap: with k = NUM_CLIENTS-1, rr_ptr returns to 0. NUM_CLIENTS not a power of two must wrap correctly, not via bit truncation.
- Handshake: the transfer completes on a cycle where req[k] and gnt[k] are both high. The client may drop or change req the next cycle. Back-to-back requests from one client are allowed; under contention each client waits at most NUM_CLIENTS-1 cycles.
- Command issue (edge ending cycle t): vram_en=1; vram_wr=req_wr[k], vram_rd=~req_wr[k]; vram_be, vram_addr and vram_data_out take client k's slices.
- Idle cycle: vram_en, vram_rd, vram_wr and vram_be are 0; vram_addr and vram_data_out hold their previous values.
- Read return: a tracking shift register of depth READ_LATENCY+1 carries {valid, client index} for reads only. vram_data_in is sampled READ_LATENCY cycles after vram_en, into rd_data. rd_valid[k] pulses for one cycle, READ_LATENCY+2 cycles after the grant cycle.
- rd_data holds its value when no read returns.
- Writes produce no rd_valid.
- Pipelining: a read may be granted every cycle; returns arrive in grant order, one per cycle, with no bubbles.
- Mixed read/write streams need no turnaround cycle.
- Reset mid-operation: in-flight reads are discarded and no rd_valid follows reset release. Arbitration resumes from client 0.
- Simultaneous events: a new grant and a read return in the same cycle are independent. A client may be granted in the same cycle its earlier read returns.

Optional Feature:
- Macro VRAM_ARB_PRIORITY_EN.
- Defined: client 0 (the renderer) has absolute priority. If req[0] is high, gnt[0] is high regardless of rr_ptr, and rr_ptr is not updated by a client-0 grant. Remaining clients are round-robin among themselves.
- Undefined: pure round-robin across all clients as above.

Test Plan:
- Single read, N=2, READ_LATENCY=1: client 1 reads addr 0x0123, model returns 0xBEEF. Expect gnt[1] in cycle 0; vram_en=1, vram_rd=1, vram_addr=0x0123 in cycle 1; rd_valid[1]=1, rd_data=0xBEEF in cycle 3; rd_valid[0] never set.
- Round-robin fairness, N=3: all req held high for 6 cycles. Expect grant order 0,1,2,0,1,2. Drop req[1] and expect order 0,2,0,2.
- Write: client 0 writes 0xA55A to 0x7FFF with be=2'b10. Expect vram_wr=1, vram_rd=0, vram_be=2'b10, vram_data_out=0xA55A one cycle after grant; no rd_valid.
- Streaming reads, READ_LATENCY=3: clients 0,1 alternate 8 reads to addresses 0..7, model data = addr+0x100. Expect 8 consecutive rd_valid pulses, alternating clients, data 0x100..0x107 in order, starting at cycle 5.
- Reset mid-flight: assert _reset one cycle after a read grant. Expect all outputs 0 immediately and no rd_valid after release. The next grant with req=3'b110 goes to client 1.
- With VRAM_ARB_PRIORITY_EN, N=3: req=3'b111 held for 4 cycles. Expect gnt[0] every cycle. Drop req[0] and expect 1,2,1.
